decimating_resampler: RTL and testbench
=======================================

Name: decimating_resampler

Overview:
Time-multiplexed 2:1 FIR decimator for NUM_CH channels, used on the capture path to bring 192/96 kHz streams down toward 48 kHz. Cascades stage-by-stage, mirroring the upsampling chain. Uses the pop/ack pull protocol on both sides:
- Downstream pops one output sample.
- The block pops two input samples upstream, runs a DEPTH-tap MAC against an external coefficient ROM, and acks the result.

Parameters:
NUM_CH, 8, number of channels
NUM_CH_LOG2, 3, log2(NUM_CH)
DEPTH, 32, FIR taps / per-channel history length (power of 2)
DEPTH_LOG2, 5, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  reset: rst, synchronous, active-high; clock clk
rst_ch  in  NUM_CH  per-channel synchronous reset
pop_o  out  NUM_CH  one-cycle request for next input sample of channel
ack_i  in  NUM_CH  input sample valid for channel
data_i  in  24*NUM_CH  signed input samples; channel c at [24c +: 24]
bank_addr_o  out  DEPTH_LOG2  coefficient ROM address
bank_data_i  in  24  signed Q1.23 coefficient, valid 1 cycle after address
pop_i  in  NUM_CH  downstream request for one output sample
data_o  out  24  signed output sample, valid while ack_o bit set
ack_o  out  NUM_CH  one-cycle output-valid pulse for channel

Behaviour:
- Reset (rst) clears state and outputs:
  - pop_o, ack_o, data_o, bank_addr_o = 0.
  - FSM = IDLE; pending = 0; all fill counters and write pointers = 0.
  - Round-robin last-served = NUM_CH-1.
- Pending requests:
  - pop_i[c] sets pending[c].
  - pop_i[c] while pending[c] is already set, or while c is active, is ignored (no second ack).
- Arbitration, in IDLE: select the first pending channel searching from last-served+1 with wrap. Latch it as active, clear its pending bit, go to FETCH. Same-cycle pops are served in round-robin order.
- FSM:
  - IDLE.
  - FETCH: pop_o[active]=1 for exactly one cycle.
  - WAIT: on ack_i[active], write data_i slice to history[active][wptr], wptr++ (wraps mod DEPTH), fill=min(fill+1,DEPTH). Second sample loops back to FETCH; after two samples go to MAC. No timeout.
  - MAC: DEPTH cycles. Cycle k drives bank_addr_o=k and reads history[active][wptr-1-k] (k=0 is newest).
  - DRAIN: 3 cycles for the ROM/RAM read, multiply and accumulate stages.
  - OUT: ack_o[active]=1 and data_o valid for one cycle; update last-served; return to IDLE.
  - Latency from MAC entry to ack_o is DEPTH+4 cycles.
- Masking: tap k contributes zero if k >= fill[active], so a freshly reset channel sees zero history.
- Arithmetic:
  - 24x24 signed product (48 bits).
  - Accumulator 48+DEPTH_LOG2 bits, cleared at MAC entry.
  - Result = (acc + 2^22) >>> 23, reduced to 24 bits per the optional feature.
- ack_i for a non-active channel, or outside WAIT, is ignored and its data discarded.
- rst_ch[c]:
  - Clears pending[c], fill[c] and wptr[c].
  - If c is active in any state other than IDLE, abort to IDLE with no ack_o and no pop_o.
  - rst_ch has priority over a same-cycle pop_i or ack_i for that channel.
- data_o holds its last value between acks (0 after rst).

Optional Feature:
DECIM_SATURATE_EN:
- Defined: result is clamped to [0x800000, 0x7FFFFF] when the shifted accumulator exceeds 24-bit signed range.
- Undefined: the low 24 bits are taken, so overflow wraps.

Decomposition:
- Shared package holds:
  - Sample width 24 and coefficient fraction bits 23.
  - The FSM state enum (IDLE, FETCH, WAIT, MAC, DRAIN, OUT).
  - The rounding constant.
- History storage is a natural sub-module, decim_history_ram:
  - NUM_CH*DEPTH x 24, one write port, one registered read port.
  - Address = {channel, index}.
- Coefficient ROM stays external, shared per stage.

Test Plan:
- Single tap: coeff[0]=0x400000, others 0; pop_i[0]; feed 0x100000 then 0x200000 -> ack_o[0] after DEPTH+4 cycles from MAC entry, data_o=0x100000.
- Fill masking: all coeffs 0x400000, rst_ch[2] then pop_i[2]; feed 0x000100, 0x000100 -> data_o=0x000100 (only 2 valid taps).
- Overflow: all coeffs 0x7FFFFF, 16 pops feeding 0x7FFFFF -> with DECIM_SATURATE_EN, final data_o=0x7FFFFF; without it, data_o equals the low 24 bits of the rounded shift (model-checked).
- Arbitration: pop_i=8'b1000_0001 in one cycle after rst -> ch0 pop_o/ack_o completes before ch7's pop_o; the next simultaneous pop on ch0 and ch7 serves ch0 again (last-served=7).
- Abort: rst_ch[3] asserted during MAC of ch3, with ch5 pending -> no ack_o[3]; next FSM activity is pop_o[5].
- Duplicate request: pop_i[1] on 3 consecutive cycles -> exactly two pop_o[1] pulses and one ack_o[1].

Source files
------------

// File: rtl/decimating_resampler_pkg.sv
// Shared definitions for the 2:1 decimating FIR resampler: sample/coefficient
// formats, rounding constant and the controller state encoding.
package decimating_resampler_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int COEF_FRAC = 23;
  localparam int PROD_W    = 2 * SAMPLE_W;

  // Half an LSB of the Q1.23 result, added before the arithmetic shift.
  localparam logic [63:0] ROUND_CONST = 64'd1 << (COEF_FRAC - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    MAC,
    DRAIN,
    OUT
  } state_t;

endpackage

// File: rtl/decim_history_ram.sv
// Per-channel sample history: NUM_CH*DEPTH words addressed {channel, index},
// one write port and one registered read port.
module decim_history_ram
  import decimating_resampler_pkg::*;
#(
  parameter int CH_W   = 3,
  parameter int IDX_W  = 5,
  parameter int DATA_W = SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [CH_W+IDX_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [CH_W+IDX_W-1:0] raddr,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**(CH_W+IDX_W)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/decimating_resampler.sv
// Time-multiplexed 2:1 FIR decimator, pop/ack pull protocol on both sides.
// Define DECIM_SATURATE_EN to clamp the result instead of wrapping on overflow.
module decimating_resampler
  import decimating_resampler_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int NUM_CH_LOG2 = 3,
  parameter int DEPTH       = 32,
  parameter int DEPTH_LOG2  = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            rst_ch,
  output logic [NUM_CH-1:0]            pop_o,
  input  logic [NUM_CH-1:0]            ack_i,
  input  logic [SAMPLE_W*NUM_CH-1:0]   data_i,
  output logic [DEPTH_LOG2-1:0]        bank_addr_o,
  input  logic [SAMPLE_W-1:0]          bank_data_i,
  input  logic [NUM_CH-1:0]            pop_i,
  output logic [SAMPLE_W-1:0]          data_o,
  output logic [NUM_CH-1:0]            ack_o
);

  localparam int ACC_W  = PROD_W + DEPTH_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;

  // Handshake: pop_o/ack_o are single-cycle pulses; a sample is taken only when
  // ack_i[active] is high while the controller waits for that channel.
  state_t                  state, state_nx;
  logic [NUM_CH-1:0]       pending;
  logic [NUM_CH_LOG2-1:0]  active, last_srv;
  logic [DEPTH_LOG2-1:0]   wptr [NUM_CH];
  logic [FILL_W-1:0]       fill [NUM_CH];
  logic                    smp_cnt;
  logic [DEPTH_LOG2-1:0]   tap;
  logic [1:0]              drain_cnt;
  logic                    s1_valid;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;

  logic [NUM_CH-1:0]       eligible, act_oh, busy_mask, grant_mask;
  logic [NUM_CH_LOG2-1:0]  grant_ch, idx;
  logic                    grant_found, act_rst, wr_en;
  logic [SAMPLE_W-1:0]     act_sample, rd_data, result;
  logic signed [ACC_W-1:0] acc_shr;

  assign eligible    = pending & ~rst_ch;
  assign act_oh      = NUM_CH'(1) << active;
  assign busy_mask   = (state != IDLE) ? act_oh : '0;
  assign grant_mask  = (state == IDLE && grant_found) ? (NUM_CH'(1) << grant_ch) : '0;
  assign act_rst     = rst_ch[active];
  assign wr_en       = (state == WAIT) && ack_i[active] && !act_rst;
  assign bank_addr_o = tap;

  // Round-robin search starting just after the last channel served.
  always_comb begin
    grant_found = 1'b0;
    grant_ch    = '0;
    idx         = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last_srv + NUM_CH_LOG2'(i);
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_ch    = idx;
      end
    end
  end

  always_comb begin
    act_sample = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (active == NUM_CH_LOG2'(c)) act_sample = data_i[SAMPLE_W*c +: SAMPLE_W];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_found) state_nx = FETCH;
      FETCH:   state_nx = WAIT;
      WAIT:    if (ack_i[active]) state_nx = smp_cnt ? MAC : FETCH;
      MAC:     if (tap == DEPTH_LOG2'(DEPTH - 1)) state_nx = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && act_rst) state_nx = IDLE;
  end

  assign acc_shr = (acc + $signed(ACC_W'(ROUND_CONST))) >>> COEF_FRAC;

`ifdef DECIM_SATURATE_EN
  logic [ACC_W-SAMPLE_W:0] shr_hi;
  assign shr_hi = acc_shr[ACC_W-1:SAMPLE_W-1];
  always_comb begin
    result = SAMPLE_W'(acc_shr);
    if (!(&shr_hi || !(|shr_hi)))
      result = acc_shr[ACC_W-1] ? 24'h800000 : 24'h7fffff;
  end
`else
  assign result = SAMPLE_W'(acc_shr);
`endif

  decim_history_ram #(
    .CH_W  (NUM_CH_LOG2),
    .IDX_W (DEPTH_LOG2),
    .DATA_W(SAMPLE_W)
  ) u_hist (
    .clk  (clk),
    .we   (wr_en),
    .waddr({active, wptr[active]}),
    .wdata(act_sample),
    .raddr({active, wptr[active] - DEPTH_LOG2'(1) - tap}),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_o     <= '0;
      ack_o     <= '0;
      data_o    <= '0;
      pending   <= '0;
      active    <= '0;
      last_srv  <= NUM_CH_LOG2'(NUM_CH - 1);
      smp_cnt   <= 1'b0;
      tap       <= '0;
      drain_cnt <= '0;
      s1_valid  <= 1'b0;
      prod      <= '0;
      acc       <= '0;
    end else begin
      pop_o   <= '0;
      ack_o   <= '0;
      pending <= (pending | (pop_i & ~busy_mask)) & ~rst_ch & ~grant_mask;
      if (state == IDLE && grant_found) begin
        active  <= grant_ch;
        smp_cnt <= 1'b0;
      end
      if (state_nx == FETCH)
        pop_o <= NUM_CH'(1) << ((state == IDLE) ? grant_ch : active);
      if (wr_en) smp_cnt <= ~smp_cnt;

      // Three-stage tap pipeline: RAM/ROM read, multiply, accumulate.
      tap       <= (state == MAC && state_nx == MAC) ? tap + DEPTH_LOG2'(1) : '0;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
      s1_valid  <= (state == MAC) && (FILL_W'(tap) < fill[active]);
      prod      <= s1_valid ? $signed(rd_data) * $signed(bank_data_i) : '0;
      if (state == WAIT && state_nx == MAC) acc <= '0;
      else acc <= acc + {{DEPTH_LOG2{prod[PROD_W-1]}}, prod};

      if (state == DRAIN && state_nx == OUT) begin
        data_o <= result;
        ack_o  <= act_oh;
      end
      if (state == OUT) last_srv <= active;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst || rst_ch[c]) begin
        wptr[c] <= '0;
        fill[c] <= '0;
      end else if (wr_en && active == NUM_CH_LOG2'(c)) begin
        wptr[c] <= wptr[c] + DEPTH_LOG2'(1);
        if (fill[c] != FILL_W'(DEPTH)) fill[c] <= fill[c] + FILL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_decimating_resampler.sv
// Directed bench for decimating_resampler: upstream responder, coefficient ROM
// model, expected-output queue and a final CHECKS/ERRORS summary.
module tb_decimating_resampler;

  localparam int NUM_CH = 8;
  localparam int DEPTH  = 32;
  localparam int W      = 24;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_CH-1:0]     rst_ch;
  logic [NUM_CH-1:0]     pop_o;
  logic [NUM_CH-1:0]     ack_i;
  logic [W*NUM_CH-1:0]   data_i;
  logic [4:0]            bank_addr_o;
  logic [W-1:0]          bank_data_i;
  logic [NUM_CH-1:0]     pop_i;
  logic [W-1:0]          data_o;
  logic [NUM_CH-1:0]     ack_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [W-1:0]   coef [DEPTH];
  logic [W-1:0]   src_q [NUM_CH][$];
  logic [W+2:0]   exp_q [$];
  int             ev_q [$];
  logic [NUM_CH-1:0] owe;
  int pop_cnt [NUM_CH];
  int ack_cnt [NUM_CH];
  int feed_cyc [NUM_CH];
  int ack_cyc [NUM_CH];

  decimating_resampler dut (
    .clk        (clk),
    .rst        (rst),
    .rst_ch     (rst_ch),
    .pop_o      (pop_o),
    .ack_i      (ack_i),
    .data_i     (data_i),
    .bank_addr_o(bank_addr_o),
    .bank_data_i(bank_data_i),
    .pop_i      (pop_i),
    .data_o     (data_o),
    .ack_o      (ack_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Coefficient ROM: data valid one cycle after address.
  always @(posedge clk) bank_data_i <= coef[bank_addr_o];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] model_out(input int n, input longint x, input longint c);
    longint s;
    s = longint'(n) * x * c + (longint'(1) << 22);
    s = s >>> 23;
`ifdef DECIM_SATURATE_EN
    if (s > 64'sd8388607) return 24'h7fffff;
    if (s < -64'sd8388608) return 24'h800000;
`endif
    return s[W-1:0];
  endfunction

  // ---------------- monitor / upstream responder / scoreboard ----------------
  initial begin
    ack_i  = '0;
    data_i = '0;
    owe    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop_cnt[c] = 0; ack_cnt[c] = 0; feed_cyc[c] = 0; ack_cyc[c] = 0;
    end
  end

  always @(negedge clk) begin
    ack_i = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (owe[c]) begin
        ack_i[c] = 1'b1;
        if (src_q[c].size() != 0) data_i[W*c +: W] = src_q[c].pop_front();
        else data_i[W*c +: W] = '0;
        feed_cyc[c] = cyc;
        owe[c] = 1'b0;
      end
      if (pop_o[c]) begin
        pop_cnt[c]++;
        ev_q.push_back(c);
        owe[c] = 1'b1;
      end
      if (ack_o[c]) begin
        logic [W+2:0] exp_v;
        ack_cnt[c]++;
        ack_cyc[c] = cyc;
        ev_q.push_back(16 + c);
        check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          check("ack_ch_data", 32'({3'(c), data_o}), 32'(exp_v));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_pop(input logic [NUM_CH-1:0] mask);
    @(negedge clk) pop_i = mask;
    @(negedge clk) pop_i = '0;
  endtask

  task automatic wait_acks(input int c, input int target, input int budget);
    for (int i = 0; i < budget && ack_cnt[c] < target; i++) @(negedge clk);
    check($sformatf("ack_count_ch%0d", c), 32'(ack_cnt[c]), 32'(target));
  endtask

  task automatic wait_pops(input int c, input int target, input int budget);
    for (int i = 0; i < budget && pop_cnt[c] < target; i++) @(negedge clk);
    check($sformatf("pop_count_ch%0d", c), 32'(pop_cnt[c]), 32'(target));
  endtask

  task automatic set_coefs(input logic [W-1:0] first, input logic [W-1:0] rest);
    for (int k = 0; k < DEPTH; k++) coef[k] = (k == 0) ? first : rest;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_p, base_a, base3;
    rst = 1'b1; rst_ch = '0; pop_i = '0;
    set_coefs(24'h0, 24'h0);
    repeat (3) @(negedge clk);
    check("rst_pop_o", 32'(pop_o), 32'd0);
    check("rst_ack_o", 32'(ack_o), 32'd0);
    check("rst_data_o", 32'(data_o), 32'd0);
    check("rst_bank_addr", 32'(bank_addr_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single tap: newest sample 0x200000 * 0.5
    set_coefs(24'h400000, 24'h0);
    src_q[0].push_back(24'h100000);
    src_q[0].push_back(24'h200000);
    exp_q.push_back({3'd0, 24'h100000});
    do_pop(8'h01);
    wait_acks(0, 1, 200);
    check("latency_mac_to_ack", 32'(ack_cyc[0] - feed_cyc[0]), 32'(DEPTH + 4));

    // Fill masking: only two taps valid after rst_ch
    set_coefs(24'h400000, 24'h400000);
    @(negedge clk) rst_ch = 8'h04;
    @(negedge clk) rst_ch = '0;
    src_q[2].push_back(24'h000100);
    src_q[2].push_back(24'h000100);
    exp_q.push_back({3'd2, 24'h000100});
    do_pop(8'h04);
    wait_acks(2, 1, 200);

    // Overflow: full-scale samples and coefficients
    set_coefs(24'h7fffff, 24'h7fffff);
    for (int i = 1; i <= 16; i++) begin
      src_q[4].push_back(24'h7fffff);
      src_q[4].push_back(24'h7fffff);
      exp_q.push_back({3'd4, model_out((2 * i < DEPTH) ? 2 * i : DEPTH, 64'h7fffff, 64'h7fffff)});
      do_pop(8'h10);
      wait_acks(4, i, 200);
    end

    // Arbitration after reset: ch0 before ch7, then ch0 again
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ev_q.delete();
    exp_q.push_back({3'd0, 24'h0});
    exp_q.push_back({3'd7, 24'h0});
    do_pop(8'h81);
    wait_acks(7, ack_cnt[7] + 1, 300);
    check("arb_first_pop_ch0", 32'(ev_q[0]), 32'd0);
    check("arb_ack0_before_pop7", 32'(ev_q[2]), 32'd16);
    check("arb_then_pop7", 32'(ev_q[3]), 32'd7);
    ev_q.delete();
    exp_q.push_back({3'd0, 24'h0});
    exp_q.push_back({3'd7, 24'h0});
    do_pop(8'h81);
    wait_acks(7, ack_cnt[7] + 1, 300);
    check("arb_rr_second_ch0", 32'(ev_q[0]), 32'd0);

    // Abort: rst_ch[3] during MAC with ch5 pending
    ev_q.delete();
    base3 = ack_cnt[3];
    do_pop(8'h08);
    wait_pops(3, pop_cnt[3] + 2, 50);
    repeat (5) @(negedge clk);
    pop_i = 8'h20;
    @(negedge clk) begin pop_i = '0; rst_ch = 8'h08; end
    @(negedge clk) rst_ch = '0;
    exp_q.push_back({3'd5, 24'h0});
    wait_acks(5, ack_cnt[5] + 1, 300);
    check("abort_no_ack3", 32'(ack_cnt[3]), 32'(base3));
    check("abort_next_pop5", 32'(ev_q[2]), 32'd5);

    // Duplicate request on ch1 held for three cycles
    base_p = pop_cnt[1];
    base_a = ack_cnt[1];
    exp_q.push_back({3'd1, 24'h0});
    @(negedge clk) pop_i = 8'h02;
    repeat (3) @(negedge clk);
    pop_i = '0;
    wait_acks(1, base_a + 1, 300);
    repeat (50) @(negedge clk);
    check("dup_pop_pulses", 32'(pop_cnt[1] - base_p), 32'd2);
    check("dup_single_ack", 32'(ack_cnt[1] - base_a), 32'd1);

    // rst_ch wins over a same-cycle pop_i
    base_p = pop_cnt[6];
    @(negedge clk) begin pop_i = 8'h40; rst_ch = 8'h40; end
    @(negedge clk) begin pop_i = '0; rst_ch = '0; end
    repeat (20) @(negedge clk);
    check("rstch_beats_pop", 32'(pop_cnt[6] - base_p), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
